// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer
// and returns a valid/ready response with read data or a timeout error.
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int RD_LAG  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [CW-1:0]     wait_inc;
    logic              timeout;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Success wins: timeout only fires on a cycle where PREADY is low.
    assign wait_inc = (wait_q == TMAX) ? wait_q : wait_q + CW'(1);
    assign timeout  = (TIMEOUT != 0) && !PREADY && (wait_inc == TMAX);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_d  = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    if (write_q) begin
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (RD_LAG == 0) begin
                        rdata_d = PRDATA;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_CAPTURE: begin
                rdata_d = PRDATA;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) && PRESETn;
    assign PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE   = (state_q == S_ACCESS);
    assign PWRITE    = write_q;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
